// File: rtl/board_eval.sv
// board_eval -- Avalon-MM chess material evaluator.
//
// Software programs a source base, a board count and a destination base
// through the slave port, then writes the start register. For each board
// the engine reads 16 words (64 squares, one signed byte per square,
// little-endian inside each word). It sums the material and writes one
// signed 32-bit score per board to dst + 4*b. It also tracks the
// best-scoring board and counts bytes that hold no legal piece code.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   slave_*                  Avalon-MM register slave (4-bit word address)
//   master_*                 Avalon-MM memory master (byte address)
//
// Register map (word index)
//   0 W: start   R: status, bit0 = done
//   1 src base   2 count (CNT_W bits)   3 dst base
//   4 best_idx   5 best_score           6 err_count
//   Other addresses read as 0 and ignore writes.
module board_eval #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    output logic [31:0] slave_readdata,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    output logic        master_write,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic [31:0] master_writedata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR,
        NEXT,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]        src_reg;
    logic [31:0]        dst_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   b_reg;
    logic [3:0]         w_reg;
    logic signed [31:0] acc_reg;
    logic signed [31:0] best_score_reg;
    logic [31:0]        best_idx_reg;
    logic [31:0]        err_count_reg;

    logic idle;
    logic start;
    logic b_last;
    logic [31:0] b_ext;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;

    // Writes to the configuration registers and the start strobe are only
    // honoured while the engine is parked.
    assign idle   = (state_reg == IDLE) || (state_reg == DONE);
    assign start  = slave_write && (slave_address == 4'd0) && idle;
    assign b_last = (({1'b0, b_reg} + 1'b1) == {1'b0, count_reg});
    assign b_ext  = 32'(b_reg);
    assign rd_addr = src_reg + (b_ext << 6) + {26'd0, w_reg, 2'b00};
    assign wr_addr = dst_reg + (b_ext << 2);

    // ------------------------------------------------------------------
    // Per-byte piece decode. The magnitude of the signed byte selects the
    // piece class and the sign selects the side. A magnitude above 48
    // is an illegal code: it scores 0 and is counted.
    // ------------------------------------------------------------------
    logic [3:0][31:0] byte_val;
    logic [3:0]       byte_err;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        logic [7:0] raw;
        logic [7:0] mag;
        logic [9:0] piece;

        assign raw   = master_readdata[8*gi +: 8];
        assign mag   = raw[7] ? (8'd0 - raw) : raw;
        assign piece = (mag == 8'd0)  ? 10'd0   :
                       (mag <= 8'd8)  ? 10'd100 :
                       (mag <= 8'd18) ? 10'd500 :
                       (mag <= 8'd28) ? 10'd320 :
                       (mag <= 8'd38) ? 10'd330 :
                       (mag <= 8'd47) ? 10'd900 : 10'd0;
        assign byte_err[gi] = (mag > 8'd48);
        assign byte_val[gi] = raw[7] ? (32'd0 - 32'(piece)) : 32'(piece);
    end

    logic signed [31:0] word_sum;
    logic [2:0]         err_inc;
    logic [32:0]        err_sum;
    logic [31:0]        err_sat;

    assign word_sum = $signed(byte_val[0]) + $signed(byte_val[1])
                    + $signed(byte_val[2]) + $signed(byte_val[3]);
    assign err_inc  = 3'(byte_err[0]) + 3'(byte_err[1])
                    + 3'(byte_err[2]) + 3'(byte_err[3]);
    // Saturate by checking the carry out of a 33-bit add.
    assign err_sum  = {1'b0, err_count_reg} + 33'(err_inc);
    assign err_sat  = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state and master outputs. The master outputs depend only on
    // registered state, so they hold steady while waitrequest stalls them.
    always_comb begin
        state_next       = state_reg;
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = 32'd0;
        master_writedata = 32'd0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (count_reg == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                master_read    = 1'b1;
                master_address = rd_addr;
                if (!master_waitrequest) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (master_readdatavalid) begin
                    state_next = (w_reg == 4'd15) ? WR : RD_REQ;
                end
            end
            WR: begin
                master_write     = 1'b1;
                master_address   = wr_addr;
                master_writedata = acc_reg;
                if (!master_waitrequest) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                state_next = b_last ? DONE : RD_REQ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            src_reg        <= 32'd0;
            dst_reg        <= 32'd0;
            count_reg      <= '0;
            b_reg          <= '0;
            w_reg          <= 4'd0;
            acc_reg        <= 32'sd0;
            best_score_reg <= 32'sh8000_0000;
            best_idx_reg   <= 32'hFFFF_FFFF;
            err_count_reg  <= 32'd0;
        end else begin
            if (idle && slave_write) begin
                case (slave_address)
                    4'd1:    src_reg   <= slave_writedata;
                    4'd2:    count_reg <= slave_writedata[CNT_W-1:0];
                    4'd3:    dst_reg   <= slave_writedata;
                    default: ;
                endcase
            end

            if (start) begin
                b_reg          <= '0;
                w_reg          <= 4'd0;
                acc_reg        <= 32'sd0;
                best_score_reg <= 32'sh8000_0000;
                best_idx_reg   <= 32'hFFFF_FFFF;
                err_count_reg  <= 32'd0;
            end

            case (state_reg)
                RD_WAIT: begin
                    if (master_readdatavalid) begin
                        acc_reg       <= acc_reg + word_sum;
                        err_count_reg <= err_sat;
                        // Wraps 15 -> 0, which is the next board's first word.
                        w_reg         <= w_reg + 4'd1;
                    end
                end
                NEXT: begin
                    // Strict compare: on a tie the earlier board stays best.
                    if (acc_reg > best_score_reg) begin
                        best_score_reg <= acc_reg;
                        best_idx_reg   <= b_ext;
                    end
                    b_reg   <= b_reg + 1'b1;
                    w_reg   <= 4'd0;
                    acc_reg <= 32'sd0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slave port. A status read that arrives mid-run is held off until the
    // run finishes (or a reset returns the engine to IDLE).
    // ------------------------------------------------------------------
    assign slave_waitrequest = slave_read && (slave_address == 4'd0) && !idle;

    always_comb begin
        slave_readdata = 32'd0;
        if (slave_read) begin
            case (slave_address)
                4'd0:    slave_readdata = {31'd0, state_reg == DONE};
                4'd1:    slave_readdata = src_reg;
                4'd2:    slave_readdata = 32'(count_reg);
                4'd3:    slave_readdata = dst_reg;
                4'd4:    slave_readdata = best_idx_reg;
                4'd5:    slave_readdata = best_score_reg;
                4'd6:    slave_readdata = err_count_reg;
                default: slave_readdata = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/board_eval.md
BOARD_EVAL -- requirements
Module: board_eval

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of the board-count register (max boards per run = 2^CNT_W - 1).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 slave_waitrequest  out  1  stalls slave read of address 0 while busy.
REQ-006 slave_address  in  4  word register index.
REQ-007 slave_read / slave_write  in  1  Avalon-MM slave strobes.
REQ-008 slave_readdata / slave_writedata  out / in  32  register data.
REQ-009 master_waitrequest  in  1  memory stall.
REQ-010 master_address  out  32  byte address.
REQ-011 master_read / master_write  out  1  Avalon-MM master strobes.
REQ-012 master_readdata  in  32  read word; byte k of the word = square (word*4 + k), little-endian.
REQ-013 master_readdatavalid  in  1  qualifies master_readdata.
REQ-014 master_writedata  out  32  signed score.

Function
REQ-015 SHALL use this register map.
- 0: write = start; read = status, bit0 = done.
- 1: src base (RW); 2: count (RW, CNT_W bits, zero-extended); 3: dst base (RW).
- 4: best_idx (RO); 5: best_score (RO); 6: err_count (RO).
- Others read 0, writes ignored.
REQ-016 slave_waitrequest SHALL be 0 except during a slave_read of address 0 while state is not IDLE/DONE.
- Accepted writes complete in one cycle.
- Writes to regs 1-3 or to start while busy SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, WR, NEXT, DONE.
- Start in IDLE/DONE: clear done, err_count and board index; best_score = 0x80000000; best_idx = 0xFFFFFFFF; go to RD_REQ, or to DONE if count = 0.
REQ-018 RD_REQ SHALL hold master_read = 1 and master_address = src + 64*b + 4*w until master_waitrequest = 0, then go to RD_WAIT.
- At most one read outstanding.
REQ-019 RD_WAIT SHALL, on master_readdatavalid, add the four byte values to the accumulator in that cycle.
- w < 15: w += 1, return to RD_REQ; w = 15: go to WR.
REQ-020 Piece values, bytes signed 8-bit.
- |v| 1-8 pawn 100; 9-18 rook 500; 19-28 knight 320; 29-38 bishop 330; 39-47 queen 900; 48 king 0.
- Positive byte adds the value; negative byte subtracts it; 0 adds 0.
REQ-021 Any byte with |v| > 48 SHALL contribute 0 and increment err_count once per byte; err_count saturates at 0xFFFFFFFF.
REQ-022 Accumulator SHALL be signed 32-bit, cleared at the start of each board.
REQ-023 WR SHALL hold master_write = 1, master_address = dst + 4*b, master_writedata = score until master_waitrequest = 0, then go to NEXT.
REQ-024 NEXT SHALL update best tracking, then increment b.
- If score > best_score, strictly (ties keep the lower index): best_score = score, best_idx = b.
- Go to DONE when b + 1 = count, else to RD_REQ with w = 0.
REQ-025 DONE SHALL set done = 1 and release any stalled status read in that cycle; a new start re-runs from REQ-017.
REQ-026 master_read and master_write SHALL never be asserted together.
REQ-027 Master strobes and address SHALL stay stable while master_waitrequest = 1.

Reset
REQ-028 rst SHALL, at the next edge, force IDLE.
- master_read = master_write = 0; slave_waitrequest = 0; slave_readdata = 0.
- src = count = dst = 0; done = 0; err_count = 0; best_idx = 0xFFFFFFFF; best_score = 0x80000000.
REQ-029 rst mid-run SHALL abandon the run: no further master strobes, no partial score written, and a stalled status read is released with 0.

Verification
REQ-030 Standard opening board at src = 0x1000, count = 1, dst = 0x2000 -> mem[0x2000] = 0; best_idx = 0; err_count = 0; exactly 16 reads, 1 write.
REQ-031 Board with WPAWN2 (0x03) at square 10 and BKNIGHT0 (0xED) at square 50, rest empty -> score 0xFFFFFF24 (-220).
REQ-032 Three boards scoring 100, 900, 900 -> writes 100/900/900 at dst, dst+4, dst+8; best_idx = 1; best_score = 900.
REQ-033 count = 0, start -> no master strobes; status read returns done = 1 within 2 cycles; best_idx = 0xFFFFFFFF.
REQ-034 One board containing byte 0x40 and byte 0xB0, rest empty -> score 0; err_count = 2.
REQ-035 master_waitrequest held 3 cycles per access, readdatavalid 4 cycles late; rst pulsed after word 7 of board 1 -> board 0 score correct, no write to dst+4, FSM in IDLE.
